// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and address helper for the sprite RAM loader.
package sprite_pkg;

  localparam logic [6:0] MAX_LINES         = 7'd32;
  localparam logic [7:0] MAX_WIDTH         = 8'd128;
  localparam int         LINE_STRIDE_BYTES = 16;
  localparam int         ADDR_W            = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Line stride is fixed at 16 bytes, so the byte address is a plain concatenation.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [4:0] l, input logic [3:0] b);
    return {l, b};
  endfunction

endpackage

// File: rtl/sprite_bit_mem.sv
// 512 x 8 sprite store: synchronous byte write, combinational single-bit read.
module sprite_bit_mem
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [2:0]        rbit,
  output logic              rdata
);

  localparam int DEPTH = int'(MAX_LINES) * LINE_STRIDE_BYTES;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr][rbit];

endmodule

// File: rtl/sprite_ram_loader.sv
// Runtime-loadable 1-bpp sprite: packs a byte stream line by line into the bit
// memory and exposes the same combinational line/offset read port as the sprite ROMs.
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter logic [6:0] HEIGHT = 7'd32,
  parameter logic [7:0] WIDTH  = 8'd128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  input  logic [6:0] line,
  input  logic [6:0] offset,
  output logic       out
);

  localparam logic [6:0] H_LIM     = (HEIGHT > MAX_LINES) ? MAX_LINES : HEIGHT;
  localparam logic [7:0] W_LIM     = (WIDTH > MAX_WIDTH) ? MAX_WIDTH : WIDTH;
  localparam logic [3:0] LAST_BYTE = 4'(W_LIM[7:3] - 5'd1);
  localparam logic [4:0] LAST_LINE = 5'(H_LIM - 7'd1);

  state_t     r_state;
  logic [4:0] r_line_cnt;
  logic [3:0] r_byte_cnt;
  logic       r_loaded;
  logic       r_in_ready;
  logic       r_busy;
  logic       r_done;

  logic w_accept;
  logic w_rdata;
  logic w_in_range;

  assign w_accept = r_in_ready & in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_line_cnt <= 5'd0;
      r_byte_cnt <= 4'd0;
      r_loaded   <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= ST_LOAD;
            r_line_cnt <= 5'd0;
            r_byte_cnt <= 4'd0;
            r_loaded   <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt <= 4'd0;
              // Final byte: stop here rather than stepping the line past HEIGHT.
              if (r_line_cnt == LAST_LINE) begin
                r_state    <= ST_DONE;
                r_loaded   <= 1'b1;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_line_cnt <= r_line_cnt + 5'd1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  sprite_bit_mem u_mem (
    .clk   (clk),
    .we    (w_accept),
    .waddr (byte_addr(r_line_cnt, r_byte_cnt)),
    .wdata (in_data),
    .raddr (byte_addr(line[4:0], offset[6:3])),
    .rbit  (offset[2:0]),
    .rdata (w_rdata)
  );

  // loaded gates the read so a reload never shows a partially written frame.
  assign w_in_range = (line < H_LIM) && ({1'b0, offset} < W_LIM);
  assign out        = r_loaded & w_in_range & w_rdata;

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
